noc_tag_sequencer: RTL

Parametrised successor to the NoC controller's filter tag generator. It walks the loop nest t (inner), r, R (outer), repeated for a programmable number of passes, and emits one (row_tag, col_tag) pair per accepted beat over a valid/ready handshake. It serves filter, ifmap and psum multicast with a runtime mode, a runtime column stride and a row offset. It sits in the NoC controller and feeds tag pairs to the GIN/GON multicast controllers.

---
 rtl/noc_pkg.sv | 24 ++
 rtl/nest_counter.sv | 69 ++++++
 rtl/noc_tag_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared types for the NoC controller tag sequencing logic.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    typedef enum logic [1:0] {
        TAG_FILTER = 2'd0,
        TAG_IFMAP  = 2'd1,
        TAG_PSUM   = 2'd2
    } tag_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam logic [1:0] c_MODE_RESERVED = 2'd3;

endpackage
`default_nettype wire

// File: rtl/nest_counter.sv
`default_nettype none
// ============================================================================
// Module      : nest_counter
// Description : Three-level wrapping loop counter (inner -> mid -> outer),
//               stepping on the falling edge of clk.
// Revision    : 1.0 - initial release
// ============================================================================
module nest_counter #(
    parameter int INNER_WIDTH = 3,
    parameter int MID_WIDTH   = 2,
    parameter int OUTER_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_clear,
    input  logic                   i_advance,
    input  logic [INNER_WIDTH-1:0] i_inner_bound,
    input  logic [MID_WIDTH-1:0]   i_mid_bound,
    input  logic [OUTER_WIDTH-1:0] i_outer_bound,
    output logic [INNER_WIDTH-1:0] o_inner_idx,
    output logic [MID_WIDTH-1:0]   o_mid_idx,
    output logic [OUTER_WIDTH-1:0] o_outer_idx,
    output logic                   o_last,
    output logic                   o_wrap
);

    logic [INNER_WIDTH-1:0] r_inner;
    logic [MID_WIDTH-1:0]   r_mid;
    logic [OUTER_WIDTH-1:0] r_outer;
    logic                   w_inner_max;
    logic                   w_mid_max;
    logic                   w_outer_max;

    assign w_inner_max = (r_inner == i_inner_bound - INNER_WIDTH'(1));
    assign w_mid_max   = (r_mid   == i_mid_bound   - MID_WIDTH'(1));
    assign w_outer_max = (r_outer == i_outer_bound - OUTER_WIDTH'(1));

    assign o_last      = w_inner_max && w_mid_max && w_outer_max;
    assign o_wrap      = i_advance && o_last;
    assign o_inner_idx = r_inner;
    assign o_mid_idx   = r_mid;
    assign o_outer_idx = r_outer;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_inner <= '0;
            r_mid   <= '0;
            r_outer <= '0;
        end else if (i_clear) begin
            r_inner <= '0;
            r_mid   <= '0;
            r_outer <= '0;
        end else if (i_advance) begin
            if (w_inner_max) begin
                r_inner <= '0;
                if (w_mid_max) begin
                    r_mid <= '0;
                    r_outer <= w_outer_max ? '0 : r_outer + OUTER_WIDTH'(1);
                end else begin
                    r_mid <= r_mid + MID_WIDTH'(1);
                end
            end else begin
                r_inner <= r_inner + INNER_WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/noc_tag_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : noc_tag_sequencer
// Description : Walks the t/r/R loop nest for a programmable number of passes
//               and emits (row_tag, col_tag) pairs over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_tag_sequencer
    import noc_pkg::*;
#(
    parameter int R_WIDTH       = 4,
    parameter int r_WIDTH       = 2,
    parameter int t_WIDTH       = 3,
    parameter int PASS_WIDTH    = 8,
    parameter int ROW_TAG_WIDTH = 4,
    parameter int COL_TAG_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [1:0]               mode,
    input  logic [R_WIDTH-1:0]       R,
    input  logic [r_WIDTH-1:0]       r,
    input  logic [t_WIDTH-1:0]       t,
    input  logic [COL_TAG_WIDTH-1:0] col_stride,
    input  logic [ROW_TAG_WIDTH-1:0] row_offset,
    input  logic [PASS_WIDTH-1:0]    passes,
    input  logic                     tag_ready,
    output logic                     tag_valid,
    output logic [ROW_TAG_WIDTH-1:0] row_tag,
    output logic [COL_TAG_WIDTH-1:0] col_tag,
    output logic                     last_tag,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_error
);

    seq_state_t               r_state;
    seq_state_t               w_state_next;
    tag_mode_t                r_mode;
    logic [R_WIDTH-1:0]       r_cfg_R;
    logic [r_WIDTH-1:0]       r_cfg_r;
    logic [t_WIDTH-1:0]       r_cfg_t;
    logic [COL_TAG_WIDTH-1:0] r_cfg_stride;
    logic [ROW_TAG_WIDTH-1:0] r_cfg_offset;
    logic [PASS_WIDTH-1:0]    r_cfg_passes;
    logic [PASS_WIDTH-1:0]    r_pass;
    logic                     r_cfg_error;

    logic [t_WIDTH-1:0]       w_t_idx;
    logic [r_WIDTH-1:0]       w_r_idx;
    logic [R_WIDTH-1:0]       w_R_idx;
    logic                     w_nest_last;
    logic                     w_nest_wrap;
    logic                     w_cfg_ok;
    logic                     w_start_take;
    logic                     w_accept;
    logic                     w_advance;
    logic                     w_last_tag;
    logic                     w_clear;

    assign w_cfg_ok     = (R != '0) && (r != '0) && (t != '0) && (passes != '0)
                          && (mode != c_MODE_RESERVED);
    assign w_start_take = (r_state == IDLE) && start && !abort;
    assign w_accept     = (r_state == RUN) && tag_ready;
    // abort wins over a simultaneous accept, so the nest must not step
    assign w_advance    = w_accept && !abort;
    assign w_last_tag   = (r_state == RUN) && w_nest_last
                          && (r_pass == r_cfg_passes - PASS_WIDTH'(1));
    assign w_clear      = (r_state != RUN) || abort || (w_advance && w_last_tag);

    nest_counter #(
        .INNER_WIDTH (t_WIDTH),
        .MID_WIDTH   (r_WIDTH),
        .OUTER_WIDTH (R_WIDTH)
    ) u_nest (
        .clk           (clk),
        .reset         (reset),
        .i_clear       (w_clear),
        .i_advance     (w_advance),
        .i_inner_bound (r_cfg_t),
        .i_mid_bound   (r_cfg_r),
        .i_outer_bound (r_cfg_R),
        .o_inner_idx   (w_t_idx),
        .o_mid_idx     (w_r_idx),
        .o_outer_idx   (w_R_idx),
        .o_last        (w_nest_last),
        .o_wrap        (w_nest_wrap)
    );

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_take && w_cfg_ok) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    w_state_next = IDLE;
                end else if (w_accept && w_last_tag) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_mode       <= TAG_FILTER;
            r_cfg_R      <= '0;
            r_cfg_r      <= '0;
            r_cfg_t      <= '0;
            r_cfg_stride <= '0;
            r_cfg_offset <= '0;
            r_cfg_passes <= '0;
            r_pass       <= '0;
            r_cfg_error  <= 1'b0;
        end else begin
            r_cfg_error <= w_start_take && !w_cfg_ok;
            if (w_start_take) begin
                r_mode       <= tag_mode_t'(mode);
                r_cfg_R      <= R;
                r_cfg_r      <= r;
                r_cfg_t      <= t;
                r_cfg_stride <= col_stride;
                r_cfg_offset <= row_offset;
                r_cfg_passes <= passes;
            end
            if (w_clear) begin
                r_pass <= '0;
            end else if (w_nest_wrap) begin
                r_pass <= r_pass + PASS_WIDTH'(1);
            end
        end
    end

    // Tag mapping: unsigned, truncated to the tag widths
    always_comb begin
        row_tag = '0;
        col_tag = '0;
        if (r_state == RUN) begin
            case (r_mode)
                TAG_IFMAP: begin
                    row_tag = ROW_TAG_WIDTH'(w_R_idx) + r_cfg_offset;
                    col_tag = COL_TAG_WIDTH'(w_t_idx) * r_cfg_stride + COL_TAG_WIDTH'(w_r_idx);
                end
                TAG_PSUM: begin
                    row_tag = ROW_TAG_WIDTH'(r_cfg_R) - ROW_TAG_WIDTH'(1)
                              - ROW_TAG_WIDTH'(w_R_idx) + r_cfg_offset;
                    col_tag = COL_TAG_WIDTH'(w_t_idx) + COL_TAG_WIDTH'(w_r_idx) * r_cfg_stride;
                end
                default: begin
                    row_tag = ROW_TAG_WIDTH'(w_R_idx) + r_cfg_offset;
                    col_tag = COL_TAG_WIDTH'(w_t_idx) + COL_TAG_WIDTH'(w_r_idx) * r_cfg_stride;
                end
            endcase
        end
    end

    assign tag_valid = (r_state == RUN);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign last_tag  = w_last_tag;
    assign cfg_error = r_cfg_error;

endmodule
`default_nettype wire
